seq_mag_cmp: RTL

- Parametrised multi-cycle magnitude comparator; successor to the 4-bit combinational equality checker.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB-first, with early exit on the first differing chunk.
- Reports eq/lt/gt plus the number of chunks examined.
- Sits beside datapath blocks that need wide compares without a long combinational chain; start/busy/done handshake.

---
 rtl/seq_mag_cmp.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_mag_cmp.sv
// Multi-cycle magnitude comparator: CHUNK bits per cycle, MSB-first, early exit on first difference.
// Optional CMP_SIGNED_EN: two's-complement operands, sign bit of the MSB chunk is flipped before comparing.
//
// state  | meaning
// IDLE   | waiting for start; results from the last compare are held
// RUN    | comparing the chunk at idx_q
// DONE   | result valid, done pulses for this single cycle
module seq_mag_cmp #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [WIDTH-1:0]                  a,
  input  logic [WIDTH-1:0]                  b,
  output logic                              busy,
  output logic                              done,
  output logic                              eq,
  output logic                              lt,
  output logic                              gt,
  output logic [$clog2(WIDTH/CHUNK):0]      cycles
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic [CHUNK-1:0] ca, cb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cyc_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  // Constant-index mux keeps the chunk select free of variable part-selects.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        ca = a_q[i*CHUNK +: CHUNK];
        cb = b_q[i*CHUNK +: CHUNK];
      end
    end
`ifdef CMP_SIGNED_EN
    if (idx_q == IW'(NCHUNK-1)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if ((ca != cb) || (idx_q == '0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    idx_d = idx_q;
    cyc_d = cyc_q;
    eq_d  = eq_q;
    lt_d  = lt_q;
    gt_d  = gt_q;
    if (state_q == S_IDLE && start) begin
      a_d   = a;
      b_d   = b;
      idx_d = IW'(NCHUNK-1);
      cyc_d = '0;
      eq_d  = 1'b0;
      lt_d  = 1'b0;
      gt_d  = 1'b0;
    end else if (state_q == S_RUN) begin
      cyc_d = cyc_q + CW'(1);
      if (ca < cb)             lt_d  = 1'b1;
      else if (ca > cb)        gt_d  = 1'b1;
      else if (idx_q == '0)    eq_d  = 1'b1;
      else                     idx_d = idx_q - IW'(1);
    end
  end

  always_comb begin
    busy   = (state_q == S_RUN);
    done   = (state_q == S_DONE);
    eq     = eq_q;
    lt     = lt_q;
    gt     = gt_q;
    cycles = cyc_q;
  end

endmodule
